// File: rtl/add16_arbiter.sv
// Round-robin sequencer sharing one external Add16 adder among NREQ requesters.
// Optional ADD16_ARB_CARRY_EN adds a registered carry_out port.
module add16_arbiter #(
  parameter int NREQ = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*16-1:0] a_in,
  input  logic [NREQ*16-1:0] b_in,
  output logic [NREQ-1:0]   ack,
  output logic [15:0]       result,
  output logic              busy,
  output logic [15:0]       add_a,
  output logic [15:0]       add_b,
  input  logic [15:0]       add_sum
`ifdef ADD16_ARB_CARRY_EN
  ,
  output logic              carry_out
`endif
);
  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [IDXW-1:0] grant_q, grant_d;
  logic [IDXW-1:0] last_grant_q, last_grant_d;
  logic [15:0]     add_a_q, add_a_d;
  logic [15:0]     add_b_q, add_b_d;
  logic [15:0]     result_q, result_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic [IDXW-1:0] pick;
  logic            pick_vld;
  logic [IDXW-1:0] cand;

  // Scan offsets from farthest to nearest so the nearest requester after
  // last_grant is the one left standing.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    cand     = '0;
    for (int off = NREQ; off >= 1; off--) begin
      cand = IDXW'((int'(last_grant_q) + off) % NREQ);
      if (req[cand]) begin
        pick     = cand;
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    add_a_d      = add_a_q;
    add_b_d      = add_b_q;
    result_d     = result_q;
    ack_d        = '0;
    case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          grant_d = pick;
          add_a_d = a_in[16*pick +: 16];
          add_b_d = b_in[16*pick +: 16];
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        result_d       = add_sum;
        ack_d[grant_q] = 1'b1;
        state_d        = S_RESP;
      end
      S_RESP: begin
        last_grant_d = grant_q;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      grant_q      <= '0;
      last_grant_q <= IDXW'(NREQ - 1);
      add_a_q      <= '0;
      add_b_q      <= '0;
      result_q     <= '0;
      ack_q        <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      add_a_q      <= add_a_d;
      add_b_q      <= add_b_d;
      result_q     <= result_d;
      ack_q        <= ack_d;
    end
  end

`ifdef ADD16_ARB_CARRY_EN
  logic carry_q, carry_d;

  // A wrapped 16-bit sum is always smaller than either operand.
  always_comb begin
    carry_d = carry_q;
    if (state_q == S_CALC) carry_d = (add_sum < add_a_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) carry_q <= 1'b0;
    else       carry_q <= carry_d;
  end

  assign carry_out = carry_q;
`endif

  assign ack    = ack_q;
  assign result = result_q;
  assign busy   = (state_q != S_IDLE);
  assign add_a  = add_a_q;
  assign add_b  = add_b_q;

endmodule

// File: tb/tb_add16_arbiter.sv
// Bench for add16_arbiter: vector table plus scoreboard of expected acks/results.
module tb_add16_arbiter;
  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [63:0] a_in;
  logic [63:0] b_in;
  logic [3:0]  ack;
  logic [15:0] result;
  logic        busy;
  logic [15:0] add_a;
  logic [15:0] add_b;
  logic [15:0] add_sum;
`ifdef ADD16_ARB_CARRY_EN
  logic        carry_out;
`endif

  add16_arbiter #(.NREQ(4)) dut (
    .clk(clk),
    .reset(reset),
    .req(req),
    .a_in(a_in),
    .b_in(b_in),
    .ack(ack),
    .result(result),
    .busy(busy),
    .add_a(add_a),
    .add_b(add_b),
    .add_sum(add_sum)
`ifdef ADD16_ARB_CARRY_EN
    ,
    .carry_out(carry_out)
`endif
  );

  // External Add16 stand-in
  assign add_sum = add_a + add_b;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [3:0]  req;
    logic [63:0] a;
    logic [63:0] b;
    logic [3:0]  exp_ack;
    logic [15:0] exp_res;
    logic        exp_c;
  } vec_t;

  typedef struct packed {
    logic [3:0]  ack;
    logic [15:0] res;
    logic        c;
  } exp_t;

  vec_t vecs [7];
  exp_t sb [$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [3:0] a, input logic [15:0] r, input logic c);
    exp_t e;
    e.ack = a;
    e.res = r;
    e.c   = c;
    sb.push_back(e);
  endtask

  // Counts rising edges until ack is seen, bounded.
  task automatic wait_ack(input string name, output int cyc);
    cyc = 0;
    while (ack == 4'b0 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (ack == 4'b0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_timeout: got no ack expected ack within 20 cycles", name);
    end
  endtask

  always @(negedge clk) begin
    if (ack !== 4'b0) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_ack: got %b expected none at %0t", ack, $time);
      end else begin
        mon_e = sb.pop_front();
        chk("ack", {28'b0, ack}, {28'b0, mon_e.ack});
        chk("result", {16'b0, result}, {16'b0, mon_e.res});
`ifdef ADD16_ARB_CARRY_EN
        chk("carry_out", {31'b0, carry_out}, {31'b0, mon_e.c});
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200us");
    $fatal(1, "watchdog");
  end

  task automatic check_reset_state(input string tag);
    chk({tag, "_ack"}, {28'b0, ack}, 32'h0);
    chk({tag, "_result"}, {16'b0, result}, 32'h0);
    chk({tag, "_busy"}, {31'b0, busy}, 32'h0);
    chk({tag, "_add_a"}, {16'b0, add_a}, 32'h0);
    chk({tag, "_add_b"}, {16'b0, add_b}, 32'h0);
  endtask

  initial begin
    int cyc;

    vecs[0] = '{4'b0001, {16'h0, 16'h0, 16'h0, 16'h0001}, {16'h0, 16'h0, 16'h0, 16'h0000},
                4'b0001, 16'h0001, 1'b0};
    vecs[1] = '{4'b0100, {16'h0, 16'hFFFF, 16'h0, 16'h0}, {16'h0, 16'hFFFF, 16'h0, 16'h0},
                4'b0100, 16'hFFFE, 1'b1};
    vecs[2] = '{4'b1010, {16'h7, 16'h0, 16'h5, 16'h0}, {16'h9, 16'h0, 16'h6, 16'h0},
                4'b1000, 16'h0010, 1'b0};
    vecs[3] = '{4'b1010, {16'h7, 16'h0, 16'h5, 16'h0}, {16'h9, 16'h0, 16'h6, 16'h0},
                4'b0010, 16'h000B, 1'b0};
    vecs[4] = '{4'b0011, {16'h0, 16'h0, 16'h8000, 16'h1234}, {16'h0, 16'h0, 16'h8000, 16'h1111},
                4'b0001, 16'h2345, 1'b0};
    vecs[5] = '{4'b0011, {16'h0, 16'h0, 16'h8000, 16'h1234}, {16'h0, 16'h0, 16'h8000, 16'h1111},
                4'b0010, 16'h0000, 1'b1};
    vecs[6] = '{4'b1111, {16'h3, 16'hABCD, 16'h2, 16'h1}, {16'h0, 16'h0001, 16'h0, 16'h0},
                4'b0100, 16'hABCE, 1'b0};

    reset = 1'b1;
    req   = '0;
    a_in  = '0;
    b_in  = '0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("reset");
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) begin
      req  = vecs[i].req;
      a_in = vecs[i].a;
      b_in = vecs[i].b;
      push_exp(vecs[i].exp_ack, vecs[i].exp_res, vecs[i].exp_c);
      wait_ack("vec", cyc);
      chk($sformatf("vec%0d_latency", i), cyc, 32'd2);
      req = '0;
      @(posedge clk); #1;
      chk($sformatf("vec%0d_busy_after", i), {31'b0, busy}, 32'h0);
      chk($sformatf("vec%0d_ack_after", i), {28'b0, ack}, 32'h0);
    end

    // Round-robin with all requesters held after a fresh reset
    reset = 1'b1;
    @(posedge clk); #1;
    check_reset_state("rr_reset");
    reset = 1'b0;
    a_in = {16'd3, 16'd2, 16'd1, 16'd0};
    b_in = {4{16'd100}};
    push_exp(4'b0001, 16'd100, 1'b0);
    push_exp(4'b0010, 16'd101, 1'b0);
    push_exp(4'b0100, 16'd102, 1'b0);
    push_exp(4'b1000, 16'd103, 1'b0);
    push_exp(4'b0001, 16'd100, 1'b0);
    req = 4'b1111;
    wait_ack("rr", cyc);
    chk("rr_first_latency", cyc, 32'd2);
    for (int k = 1; k < 5; k++) begin
      @(posedge clk); #1;
      wait_ack("rr", cyc);
      chk($sformatf("rr%0d_spacing", k), cyc + 1, 32'd3);
    end
    req = '0;
    @(posedge clk); #1;
    chk("rr_busy_after", {31'b0, busy}, 32'h0);

    // Withdrawal during CALC still completes
    a_in = {16'd7, 48'h0};
    b_in = {16'd8, 48'h0};
    req  = 4'b1000;
    push_exp(4'b1000, 16'd15, 1'b0);
    @(posedge clk); #1;
    chk("wd_busy", {31'b0, busy}, 32'h1);
    chk("wd_add_a", {16'b0, add_a}, 32'd7);
    chk("wd_add_b", {16'b0, add_b}, 32'd8);
    req = '0;
    wait_ack("wd", cyc);
    chk("wd_latency", cyc, 32'd1);
    @(posedge clk); #1;
    chk("wd_busy_after", {31'b0, busy}, 32'h0);

    // Reset during CALC drops the operation
    a_in = {16'h0, 16'd3, 32'h0};
    b_in = {16'h0, 16'd4, 32'h0};
    req  = 4'b0100;
    @(posedge clk); #1;
    chk("rm_busy_pre", {31'b0, busy}, 32'h1);
    chk("rm_add_a_pre", {16'b0, add_a}, 32'd3);
    reset = 1'b1;
    #1;
    check_reset_state("rm");
    req = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    chk("rm_idle_ack", {28'b0, ack}, 32'h0);
    a_in = {16'd3, 16'd2, 16'd1, 16'd0};
    b_in = {4{16'd100}};
    req  = 4'b1111;
    push_exp(4'b0001, 16'd100, 1'b0);
    wait_ack("rm_regrant", cyc);
    chk("rm_regrant_latency", cyc, 32'd2);
    req = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;

    chk("sb_drained", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/add16_arbiter.md
# add16_arbiter

Round-robin arbiter and sequencer that shares one Add16 combinational adder among NREQ requesters. It sits between the requesting units and a single Add16 instance. It latches the chosen requester's operands into the adder, registers the 16-bit sum and returns it with a one-cycle acknowledge pulse. One operation completes every 3 clock cycles.

## Interface
- NREQ, default 4: number of requesters, 2..8.
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  NREQ  per-requester request level; bit i belongs to requester i.
- a_in  input  NREQ*16  operand A of requester i, in bits [16*i+15:16*i].
- b_in  input  NREQ*16  operand B of requester i, same packing as a_in.
- ack  output  NREQ  one-hot pulse, one cycle long; result is valid while it is high.
- result  output  16  registered sum of the last completed operation.
- busy  output  1  high in every state except IDLE.
- add_a  output  16  registered operand A, driven to the Add16 .a input.
- add_b  output  16  registered operand B, driven to the Add16 .b input.
- add_sum  input  16  sum returned from the Add16 .out output.

## Operation
- FSM states: IDLE, CALC, RESP. Reset state is IDLE.
- IDLE:
  - If req is nonzero, grant the first set bit searching upward from last_grant+1 (mod NREQ).
  - Latch that requester's a_in and b_in into add_a and add_b, record the grant index, and go to CALC.
  - If req is zero, stay in IDLE and hold add_a, add_b and result.
- CALC: result <= add_sum; go to RESP.
- RESP:
  - ack[grant] = 1 and all other ack bits = 0.
  - last_grant <= grant; go to IDLE.
- Arithmetic is modulo 2^16. Carry out of bit 15 is discarded unless the Configuration macro is defined.
- Requester contract: hold req and operands stable until ack is seen, then drop req in the following cycle. If req is still high in IDLE after the ack, that counts as a new request.
- Dropping req during CALC or RESP does not abort the operation. The ack still pulses.
- A request that arrives while busy waits. It is only evaluated in IDLE.
- Reset values: ack=0, result=0, add_a=0, add_b=0, busy=0, grant=0, last_grant=NREQ-1, so requester 0 has first priority.
- Reset asserted mid-operation forces IDLE immediately. The pending operation is dropped, no ack is issued, and the requester must re-request.

## Timing
- Edge E0 (IDLE, req nonzero): after E0, add_a, add_b and busy are valid.
- Edge E1: result is captured and ack rises.
- Edge E2: ack falls and busy falls.
- Latency: ack is high during the 2nd cycle after the sampling edge.
- Throughput: at most 1 grant per 3 cycles, with no idle gap forced beyond that.
- ack and result are registered; no output has a combinational path from req.
- With all NREQ requesters continuously asserted, grants rotate 0,1,…,NREQ-1,0. A requester waits at most NREQ-1 operations.

## Configuration
- ADD16_ARB_CARRY_EN:
  - Defined: adds output port carry_out (1 bit). It is registered in CALC as (add_sum < add_a), valid with result, and reset value 0.
  - Undefined: the port is absent and no carry logic is built.

## Test plan
- Single request: after reset, req=4'b0001, a=1, b=0 → ack=4'b0001 on the 2nd cycle after sampling, result=1, then busy=0.
- Wrap-around: requester 2 with a=16'hFFFF, b=16'hFFFF → result=16'hFFFE and ack=4'b0100. With ADD16_ARB_CARRY_EN, carry_out=1.
- Round-robin fairness: req=4'b1111 held, with requester i using a=i, b=100 → ack order 0,1,2,3,0 with results 100,101,102,103,100, and each ack 3 cycles apart.
- Simultaneous arrival after a grant: requester 1 completes, then req=4'b0011 → requester 1 is skipped until requester 0 has been served, so ack order is 0 then 1.
- Withdrawal: req[3] dropped during CALC with a=7, b=8 → ack[3] still pulses and result=15.
- Reset mid-operation: reset asserted during CALC → ack never pulses; result=0, busy=0 and add_a=0 immediately. The first grant after release goes to requester 0 when req=4'b1111.
